adder8_seq: RTL and testbench
=============================

# adder8_seq

Multi-precision add sequencer that computes NBYTES-wide sums by time-multiplexing one combinational `adder8` byte adder. A byte counter walks the operand lanes LSB first and chains carry-out into the next lane's carry-in. Operands enter through a valid/ready handshake and results leave through one. Sits between a register-file/accumulator front end and the shared `adder8` datapath, replacing a wide ripple adder where area matters more than latency.

## Interface

**Parameters**
- `NBYTES`, default 4: operand width in bytes; legal range 1..16.

**Ports**
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: operands and carry-in are valid.
- `in_ready`, output, 1: block can accept an operation.
- `in_a`, input, 8*NBYTES: operand A.
- `in_b`, input, 8*NBYTES: operand B.
- `in_cin`, input, 1: initial carry-in.
- `in_sub`, input, 1: subtract select; present only with `ADDER8_SEQ_SUB_EN`.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `out_sum`, output, 8*NBYTES: result.
- `out_cout`, output, 1: carry out of the MSB lane.

## Operation

- **States:** IDLE, RUN, DONE.
  - IDLE → RUN on `in_valid && in_ready`.
  - RUN → DONE when the byte counter equals NBYTES-1.
  - DONE → IDLE on `out_ready`.
- **Capture:** on accept, register `in_a`, `in_b` and carry = `in_cin`, and set the counter to 0. Inputs are sampled only on the accept edge; later changes are ignored.
- **RUN cycle k:**
  - Lane k of the A/B registers drives `adder8` with `a`, `b`, and `cin` = carry register.
  - At the edge, `sum` is written to `out_sum[8k+7:8k]`, `cout` is written to the carry register, and the counter increments.
- **Final lane:** at the last lane's edge, the carry is also written to `out_cout`.
- **Arithmetic:** the result is exactly (A + B + cin) mod 2^(8·NBYTES), and `out_cout` is bit 8·NBYTES of the full sum.
- **Counter:** width max(1, $clog2(NBYTES)). It never wraps past NBYTES-1.
- **Handshake outputs:**
  - `in_ready` = 1 only in IDLE.
  - `out_valid` = 1 only in DONE.
  - `in_valid` while not in IDLE has no effect.
- **Output stability:** `out_sum` and `out_cout` are held stable while `out_valid && !out_ready`. Their contents outside DONE are don't-care to consumers but are deterministic.
- **NBYTES = 1:** RUN lasts exactly one cycle.

## Timing

- **Reset values:** state IDLE, `in_ready` = 1, `out_valid` = 0, `out_sum` = 0, `out_cout` = 0, carry = 0, counter = 0.
- **Latency:** with accept at edge E0, `out_valid` rises after edge E(NBYTES) and is visible in the cycle following it.
- **Back-to-back:** at minimum one operation per NBYTES+2 cycles:
  - `in_ready` returns in the cycle after the `out_ready` handshake edge.
  - There is no same-cycle result/accept overlap.
- **Reset mid-operation (RUN or DONE):** the operation is abandoned with no partial result exposed. The next cycle is IDLE with all outputs at reset values.
- **Reset and handshake in the same cycle:** reset wins.

## Configuration

- **`ADDER8_SEQ_SUB_EN` defined:**
  - The `in_sub` port exists and is captured on accept.
  - When it is 1, each lane feeds `~b` to `adder8`, and the initial carry is forced to 1 (`in_cin` is ignored). The result is A − B mod 2^(8·NBYTES).
  - `out_cout` = 1 means no borrow.
- **Macro undefined:**
  - The `in_sub` port and the inversion logic are absent.
  - The block only adds.

## Structure

- **Package `adder8_seq_pkg`:**
  - the state enum typedef (IDLE, RUN, DONE);
  - localparam `BYTE_W = 8`.
- **Sub-module:** instantiates the existing `adder8` (ports `a`, `b`, `cin`, `sum`, `cout`) exactly once, by name. No other sub-module is needed.

## Test plan

All scenarios use NBYTES = 4 unless noted.

- **Reset:** hold `rst` 2 cycles → `in_ready` = 1, `out_valid` = 0, `out_sum` = 0, `out_cout` = 0.
- **Simple add:** A = 0x00000004, B = 0x00000011, cin = 0 → `out_sum` = 0x00000015, `out_cout` = 0. `out_valid` is first seen 4 cycles after the accept edge.
- **Carry ripple:**
  - A = 0x00FFFFFF, B = 0x00000001, cin = 0 → 0x01000000, cout 0.
  - A = 0xFFFFFFFF, B = 0, cin = 1 → 0x00000000, cout 1.
- **Backpressure:** `out_ready` = 0 for 5 cycles with `in_valid` held high and new operands driven → `out_valid`, `out_sum` and `out_cout` stay stable and `in_ready` stays 0. The second operation is accepted only after the result handshake.
- **Reset mid-RUN:** assert `rst` at RUN lane 2 → next cycle IDLE with reset outputs. A subsequent A = 200, B = 55, cin = 1 → 0x00000100, cout 0.
- **Subtract (`ADDER8_SEQ_SUB_EN`):**
  - A = 0x10, B = 0x11, `in_sub` = 1 → 0xFFFFFFFF, cout 0.
  - A = 0x11, B = 0x10 → 0x00000001, cout 1.
  - Repeat the subtract scenario with NBYTES = 1.

Source files
------------

// File: rtl/adder8_seq_pkg.sv
// ----------------------------------------------------------------------------
// adder8_seq_pkg
//   Shared types and constants for the adder8_seq multi-precision add
//   sequencer and its byte-adder datapath.
//
//   Contents:
//     BYTE_W    - width of one operand lane (the adder8 datapath width)
//     state_e   - sequencer state encoding (IDLE, RUN, DONE)
//     cnt_width - lane counter width for a given operand byte count
// ----------------------------------------------------------------------------
package adder8_seq_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-lane sequencer still needs a 1-bit counter so that the
    // lane-select and last-lane compare stay well formed.
    function automatic int unsigned cnt_width(input int unsigned nbytes);
        if (nbytes > 1) begin
            return int'($clog2(nbytes));
        end
        return 1;
    endfunction

endpackage

// File: rtl/adder8_seq_adder8.sv
// ----------------------------------------------------------------------------
// adder8
//   Combinational 8-bit adder with carry in/out. This is the shared byte
//   datapath that adder8_seq time-multiplexes across operand lanes.
//
//   Ports:
//     a    in  [7:0]  addend A
//     b    in  [7:0]  addend B
//     cin  in         carry in
//     sum  out [7:0]  (a + b + cin) mod 256
//     cout out        carry out (bit 8 of a + b + cin)
// ----------------------------------------------------------------------------
module adder8
    import adder8_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
    assign sum  = full[BYTE_W-1:0];
    assign cout = full[BYTE_W];

endmodule

// File: rtl/adder8_seq.sv
// ----------------------------------------------------------------------------
// adder8_seq
//   Multi-precision add sequencer. Computes an NBYTES-wide sum by walking the
//   operand lanes LSB first through one shared adder8, chaining each lane's
//   carry-out into the next lane's carry-in. One lane is processed per clock.
//
//   Parameters:
//     NBYTES      operand width in bytes (1..16)
//
//   Ports:
//     clk         in   clock, all state updates on the rising edge
//     rst         in   synchronous active-high reset
//     in_valid    in   operands and carry-in valid
//     in_ready    out  sequencer idle and able to accept an operation
//     in_a        in   operand A  [8*NBYTES-1:0]
//     in_b        in   operand B  [8*NBYTES-1:0]
//     in_cin      in   initial carry-in
//     in_sub      in   subtract select (only with ADDER8_SEQ_SUB_EN)
//     out_valid   out  result valid
//     out_ready   in   consumer accepts the result
//     out_sum     out  result     [8*NBYTES-1:0]
//     out_cout    out  carry out of the MSB lane
//
//   Build option:
//     ADDER8_SEQ_SUB_EN  adds the in_sub port. When in_sub is captured as 1,
//                        each lane adds ~B and the initial carry is forced to
//                        1, giving A - B; out_cout = 1 then means no borrow.
// ----------------------------------------------------------------------------
module adder8_seq
    import adder8_seq_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] in_a,
    input  logic [BYTE_W*NBYTES-1:0] in_b,
    input  logic                     in_cin,
`ifdef ADDER8_SEQ_SUB_EN
    input  logic                     in_sub,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] out_sum,
    output logic                     out_cout
);

    localparam int unsigned W  = BYTE_W * NBYTES;
    localparam int unsigned CW = cnt_width(NBYTES);
    localparam logic [CW-1:0] LAST_LANE = CW'(NBYTES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            carry_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic            in_ready_q;
    logic            out_valid_q;
`ifdef ADDER8_SEQ_SUB_EN
    logic            sub_q;
`endif

    // ------------------------------------------------------------------
    // Lane datapath
    // ------------------------------------------------------------------
    logic [BYTE_W-1:0] lane_a;
    logic [BYTE_W-1:0] lane_b;
    logic [BYTE_W-1:0] lane_sum;
    logic              lane_cout;
    logic [W-1:0]      sum_d;
    logic              carry_init_d;

    // Select the active lane of the captured operands.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (cnt_q == CW'(i)) begin
                lane_a = a_q[i*BYTE_W +: BYTE_W];
                lane_b = b_q[i*BYTE_W +: BYTE_W];
            end
        end
`ifdef ADDER8_SEQ_SUB_EN
        if (sub_q) begin
            lane_b = ~lane_b;
        end
`endif
    end

    adder8 u_adder8 (
        .a    (lane_a),
        .b    (lane_b),
        .cin  (carry_q),
        .sum  (lane_sum),
        .cout (lane_cout)
    );

    // Merge the current lane's sum into the result register image.
    always_comb begin
        sum_d = sum_q;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (cnt_q == CW'(i)) begin
                sum_d[i*BYTE_W +: BYTE_W] = lane_sum;
            end
        end
    end

    // Subtraction is A + ~B + 1, so the initial carry is forced high.
    always_comb begin
        carry_init_d = in_cin;
`ifdef ADDER8_SEQ_SUB_EN
        if (in_sub) begin
            carry_init_d = 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with registered handshake outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ADDER8_SEQ_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= in_a;
                        b_q        <= in_b;
                        carry_q    <= carry_init_d;
                        cnt_q      <= '0;
`ifdef ADDER8_SEQ_SUB_EN
                        sub_q      <= in_sub;
`endif
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end

                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= lane_cout;
                    if (cnt_q == LAST_LANE) begin
                        // Counter holds at the last lane rather than wrapping.
                        cout_q      <= lane_cout;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_adder8_seq.sv
module tb_adder8_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 4-byte DUT
    logic        d4_in_valid = 1'b0;
    logic        d4_in_ready;
    logic [31:0] d4_in_a = '0;
    logic [31:0] d4_in_b = '0;
    logic        d4_in_cin = 1'b0;
    logic        d4_out_valid;
    logic        d4_out_ready = 1'b0;
    logic [31:0] d4_out_sum;
    logic        d4_out_cout;

    // 1-byte DUT
    logic        d1_in_valid = 1'b0;
    logic        d1_in_ready;
    logic [7:0]  d1_in_a = '0;
    logic [7:0]  d1_in_b = '0;
    logic        d1_in_cin = 1'b0;
    logic        d1_out_valid;
    logic        d1_out_ready = 1'b0;
    logic [7:0]  d1_out_sum;
    logic        d1_out_cout;

`ifdef ADDER8_SEQ_SUB_EN
    logic d4_in_sub = 1'b0;
    logic d1_in_sub = 1'b0;
`endif

    logic [32:0] q4[$];
    logic [8:0]  q1[$];
    int tests = 0;
    int fails = 0;
    int unsigned last_accept = 0;

    adder8_seq #(.NBYTES(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d4_in_valid),
        .in_ready  (d4_in_ready),
        .in_a      (d4_in_a),
        .in_b      (d4_in_b),
        .in_cin    (d4_in_cin),
`ifdef ADDER8_SEQ_SUB_EN
        .in_sub    (d4_in_sub),
`endif
        .out_valid (d4_out_valid),
        .out_ready (d4_out_ready),
        .out_sum   (d4_out_sum),
        .out_cout  (d4_out_cout)
    );

    adder8_seq #(.NBYTES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d1_in_valid),
        .in_ready  (d1_in_ready),
        .in_a      (d1_in_a),
        .in_b      (d1_in_b),
        .in_cin    (d1_in_cin),
`ifdef ADDER8_SEQ_SUB_EN
        .in_sub    (d1_in_sub),
`endif
        .out_valid (d1_out_valid),
        .out_ready (d1_out_ready),
        .out_sum   (d1_out_sum),
        .out_cout  (d1_out_cout)
    );

    // Reference: full-width sum, MSB is the carry out.
    function automatic logic [32:0] model4(input logic [31:0] a, input logic [31:0] b,
                                           input logic cin, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + 33'd1;
        return {1'b0, a} + {1'b0, b} + {32'd0, cin};
    endfunction

    function automatic logic [8:0] model1(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + 9'd1;
        return {1'b0, a} + {1'b0, b} + {8'd0, cin};
    endfunction

    // All tasks start and end at #1 after a rising edge.
    task automatic issue4(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input bit track);
        int n = 0;
        while (d4_in_ready !== 1'b1 && n < 64) begin
            @(posedge clk); #1; n++;
        end
        if (d4_in_ready !== 1'b1) begin
            tests++; fails++;
            $display("FAIL issue4_timeout: in_ready=%b required 1", d4_in_ready);
        end
        d4_in_a = a; d4_in_b = b; d4_in_cin = cin; d4_in_valid = 1'b1;
`ifdef ADDER8_SEQ_SUB_EN
        d4_in_sub = sub;
`endif
        if (track) q4.push_back(model4(a, b, cin, sub));
        @(posedge clk); #1;
        last_accept = cyc;
        // Scramble the inputs: only the accept-edge values may matter.
        d4_in_valid = 1'b0;
        d4_in_a = $urandom; d4_in_b = $urandom; d4_in_cin = 1'($urandom);
`ifdef ADDER8_SEQ_SUB_EN
        d4_in_sub = ~sub;
`endif
    endtask

    task automatic wait4(output int n);
        n = 0;
        while (d4_out_valid !== 1'b1 && n < 64) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic collect4(output logic [32:0] got, output logic [32:0] exp);
        got = {d4_out_cout, d4_out_sum};
        exp = (q4.size() > 0) ? q4.pop_front() : 33'bx;
        d4_out_ready = 1'b1;
        @(posedge clk); #1;
        d4_out_ready = 1'b0;
    endtask

    task automatic issue1(input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub);
        int n = 0;
        while (d1_in_ready !== 1'b1 && n < 64) begin
            @(posedge clk); #1; n++;
        end
        if (d1_in_ready !== 1'b1) begin
            tests++; fails++;
            $display("FAIL issue1_timeout: in_ready=%b required 1", d1_in_ready);
        end
        d1_in_a = a; d1_in_b = b; d1_in_cin = cin; d1_in_valid = 1'b1;
`ifdef ADDER8_SEQ_SUB_EN
        d1_in_sub = sub;
`endif
        q1.push_back(model1(a, b, cin, sub));
        @(posedge clk); #1;
        d1_in_valid = 1'b0;
        d1_in_a = 8'($urandom); d1_in_b = 8'($urandom); d1_in_cin = 1'($urandom);
`ifdef ADDER8_SEQ_SUB_EN
        d1_in_sub = ~sub;
`endif
    endtask

    task automatic wait1(output int n);
        n = 0;
        while (d1_out_valid !== 1'b1 && n < 64) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic collect1(output logic [8:0] got, output logic [8:0] exp);
        got = {d1_out_cout, d1_out_sum};
        exp = (q1.size() > 0) ? q1.pop_front() : 9'bx;
        d1_out_ready = 1'b1;
        @(posedge clk); #1;
        d1_out_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        d4_in_valid = 1'b1; d1_in_valid = 1'b1;   // reset must win
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        d4_in_valid = 1'b0; d1_in_valid = 1'b0;
        tests++; if (d4_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b required 1", d4_in_ready); end
        tests++; if (d4_out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", d4_out_valid); end
        tests++; if (d4_out_sum !== 32'h0) begin fails++; $display("FAIL reset_out_sum: got %h required 00000000", d4_out_sum); end
        tests++; if (d4_out_cout !== 1'b0) begin fails++; $display("FAIL reset_out_cout: got %b required 0", d4_out_cout); end
        tests++; if (d1_in_ready !== 1'b1 || d1_out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_nb1_handshake: got ready=%b valid=%b required 1 0", d1_in_ready, d1_out_valid);
        end
    endtask

    task automatic test_simple_add();
        int n;
        logic [32:0] got, exp;
        issue4(32'h4, 32'h11, 1'b0, 1'b0, 1'b1);
        wait4(n);
        tests++; if (n !== 4) begin fails++; $display("FAIL simple_latency: got %0d required 4", n); end
        collect4(got, exp);
        tests++; if (got !== exp) begin fails++; $display("FAIL simple_sum: got %h required %h", got, exp); end
        tests++; if (d4_in_ready !== 1'b1 || d4_out_valid !== 1'b0) begin
            fails++; $display("FAIL simple_ready_return: got ready=%b valid=%b required 1 0", d4_in_ready, d4_out_valid);
        end
    endtask

    task automatic test_carry_ripple();
        int n;
        logic [32:0] got, exp;
        issue4(32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        wait4(n);
        collect4(got, exp);
        tests++; if (got !== exp) begin fails++; $display("FAIL ripple_24: got %h required %h", got, exp); end
        issue4(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b1);
        wait4(n);
        collect4(got, exp);
        tests++; if (got !== exp) begin fails++; $display("FAIL ripple_full: got %h required %h", got, exp); end
    endtask

    task automatic test_backpressure();
        int n;
        logic [32:0] got, exp;
        issue4(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 1'b1);
        wait4(n);
        d4_in_a = 32'hDEAD_0001; d4_in_b = 32'h0000_BEEF; d4_in_cin = 1'b0; d4_in_valid = 1'b1;
`ifdef ADDER8_SEQ_SUB_EN
        d4_in_sub = 1'b0;
`endif
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++;
            if ({d4_out_cout, d4_out_sum} !== q4[0] || d4_out_valid !== 1'b1 || d4_in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got %h valid=%b ready=%b required %h 1 0",
                         i, {d4_out_cout, d4_out_sum}, d4_out_valid, d4_in_ready, q4[0]);
            end
        end
        collect4(got, exp);
        tests++; if (got !== exp) begin fails++; $display("FAIL bp_first: got %h required %h", got, exp); end
        tests++; if (d4_in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_after_handshake: got %b required 1", d4_in_ready); end
        q4.push_back(model4(32'hDEAD_0001, 32'h0000_BEEF, 1'b0, 1'b0));
        @(posedge clk); #1;
        d4_in_valid = 1'b0;
        tests++; if (d4_in_ready !== 1'b0) begin fails++; $display("FAIL bp_second_accept: ready got %b required 0", d4_in_ready); end
        wait4(n);
        tests++; if (n !== 4) begin fails++; $display("FAIL bp_second_latency: got %0d required 4", n); end
        collect4(got, exp);
        tests++; if (got !== exp) begin fails++; $display("FAIL bp_second: got %h required %h", got, exp); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        bit seen;
        logic [32:0] got, exp;
        issue4(32'h1122_3344, 32'h0101_0101, 1'b0, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end   // now in lane 2
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++; if (d4_in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready: got %b required 1", d4_in_ready); end
        tests++; if (d4_out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid: got %b required 0", d4_out_valid); end
        tests++; if (d4_out_sum !== 32'h0 || d4_out_cout !== 1'b0) begin
            fails++; $display("FAIL midrst_outputs: got %h/%b required 00000000/0", d4_out_sum, d4_out_cout);
        end
        seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (d4_out_valid !== 1'b0) seen = 1'b1; end
        tests++; if (seen) begin fails++; $display("FAIL midrst_no_result: out_valid got 1 required 0"); end
        issue4(32'd200, 32'd55, 1'b1, 1'b0, 1'b1);
        wait4(n);
        collect4(got, exp);
        tests++; if (got !== exp) begin fails++; $display("FAIL midrst_next: got %h required %h", got, exp); end
    endtask

    task automatic test_nbytes1();
        int n;
        logic [8:0] got, exp;
        issue1(8'hFF, 8'h01, 1'b0, 1'b0);
        wait1(n);
        tests++; if (n !== 1) begin fails++; $display("FAIL nb1_latency: got %0d required 1", n); end
        collect1(got, exp);
        tests++; if (got !== exp) begin fails++; $display("FAIL nb1_carry: got %h required %h", got, exp); end
        issue1(8'h12, 8'h34, 1'b1, 1'b0);
        wait1(n);
        collect1(got, exp);
        tests++; if (got !== exp) begin fails++; $display("FAIL nb1_add: got %h required %h", got, exp); end
    endtask

`ifdef ADDER8_SEQ_SUB_EN
    task automatic test_subtract();
        int n;
        logic [32:0] got, exp;
        logic [8:0]  got1, exp1;
        issue4(32'h10, 32'h11, 1'b0, 1'b1, 1'b1);
        wait4(n);
        collect4(got, exp);
        tests++; if (got !== exp) begin fails++; $display("FAIL sub_borrow: got %h required %h", got, exp); end
        issue4(32'h11, 32'h10, 1'b0, 1'b1, 1'b1);
        wait4(n);
        collect4(got, exp);
        tests++; if (got !== exp) begin fails++; $display("FAIL sub_noborrow: got %h required %h", got, exp); end
        issue1(8'h10, 8'h11, 1'b0, 1'b1);
        wait1(n);
        collect1(got1, exp1);
        tests++; if (got1 !== exp1) begin fails++; $display("FAIL nb1_sub_borrow: got %h required %h", got1, exp1); end
        issue1(8'h11, 8'h10, 1'b0, 1'b1);
        wait1(n);
        collect1(got1, exp1);
        tests++; if (got1 !== exp1) begin fails++; $display("FAIL nb1_sub_noborrow: got %h required %h", got1, exp1); end
    endtask
`endif

    task automatic test_back_to_back();
        int n;
        int unsigned prev;
        logic [32:0] got, exp;
        logic sub;
        d4_out_ready = 1'b1;
        prev = 0;
        for (int k = 0; k < 10; k++) begin
            sub = 1'b0;
`ifdef ADDER8_SEQ_SUB_EN
            sub = 1'($urandom);
`endif
            issue4($urandom, $urandom, 1'($urandom), sub, 1'b1);
            if (k > 0) begin
                tests++;
                if (last_accept - prev !== 6) begin
                    fails++; $display("FAIL b2b_period[%0d]: got %0d required 6", k, last_accept - prev);
                end
            end
            prev = last_accept;
            wait4(n);
            got = {d4_out_cout, d4_out_sum};
            exp = q4.pop_front();
            tests++; if (got !== exp) begin fails++; $display("FAIL b2b_result[%0d]: got %h required %h", k, got, exp); end
            @(posedge clk); #1;   // handshake edge
        end
        d4_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_simple_add();
        test_carry_ripple();
        test_backpressure();
        test_reset_mid_run();
        test_nbytes1();
`ifdef ADDER8_SEQ_SUB_EN
        test_subtract();
`endif
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
